// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: one-hot operation selects and the shift-amount width.
// Pure declarations; no logic.
package alu_pkg;
  localparam logic [7:0] SEL_ADD = 8'b0000_0001;
  localparam logic [7:0] SEL_SUB = 8'b0000_0010;
  localparam logic [7:0] SEL_AND = 8'b0000_0100;
  localparam logic [7:0] SEL_OR  = 8'b0000_1000;
  localparam logic [7:0] SEL_XOR = 8'b0001_0000;
  localparam logic [7:0] SEL_NOR = 8'b0010_0000;
  localparam logic [7:0] SEL_SHL = 8'b0100_0000;
  localparam logic [7:0] SEL_SHR = 8'b1000_0000;

  localparam int SHAMT_W = 3;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU function of op1/op2 under a one-hot select; flags added with ALU_FLAGS_EN.
// Latency: 0 (pure combinational).
// Backpressure: none; output follows inputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [7:0]       select,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             sel_err
`endif
);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   add_r;
  logic [WIDTH-1:0]   sub_r;

  assign shamt = op2[SHAMT_W-1:0];

`ifdef ALU_FLAGS_EN
  logic add_c;
  logic sub_b;
  // Extra top bit of the widened add/sub is carry-out / borrow.
  assign {add_c, add_r} = {1'b0, op1} + {1'b0, op2};
  assign {sub_b, sub_r} = {1'b0, op1} - {1'b0, op2};
`else
  assign add_r = op1 + op2;
  assign sub_r = op1 - op2;
`endif

  // Exact match on each one-hot code; anything else (zero or multi-hot) yields 0.
  always_comb begin
    result = '0;
    case (select)
      SEL_ADD: result = add_r;
      SEL_SUB: result = sub_r;
      SEL_AND: result = op1 & op2;
      SEL_OR:  result = op1 | op2;
      SEL_XOR: result = op1 ^ op2;
      SEL_NOR: result = ~(op1 | op2);
      SEL_SHL: result = op1 << shamt;
      SEL_SHR: result = op1 >> shamt;
      default: result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    carry   = 1'b0;
    ovf     = 1'b0;
    sel_err = 1'b0;
    case (select)
      SEL_ADD: begin
        carry = add_c;
        ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_r[WIDTH-1] != op1[WIDTH-1]);
      end
      SEL_SUB: begin
        carry = sub_b;
        ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_r[WIDTH-1] != op1[WIDTH-1]);
      end
      SEL_AND, SEL_OR, SEL_XOR, SEL_NOR, SEL_SHL, SEL_SHR: begin
      end
      default: sel_err = 1'b1;
    endcase
  end

  assign zero = (result == '0);
`endif

endmodule

// File: rtl/alu.sv
// Registered 8-op ALU with one-hot select; optional flag outputs under ALU_FLAGS_EN.
// Latency: 1 cycle, one op accepted per cycle.
// Backpressure: none; synchronous active-high rst clears all outputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [7:0]       select,
  output logic [WIDTH-1:0] res
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             sel_err
`endif
);

  logic [WIDTH-1:0] result;
`ifdef ALU_FLAGS_EN
  logic carry_c, zero_c, ovf_c, sel_err_c;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op1     (op1),
    .op2     (op2),
    .select  (select),
    .result  (result)
`ifdef ALU_FLAGS_EN
    ,
    .carry   (carry_c),
    .zero    (zero_c),
    .ovf     (ovf_c),
    .sel_err (sel_err_c)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else begin
      res <= result;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      carry   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      carry   <= carry_c;
      zero    <= zero_c;
      ovf     <= ovf_c;
      sel_err <= sel_err_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors then randomized ops against an arithmetic model.
module tb_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] op1, op2, select;
  logic [7:0] res;
`ifdef ALU_FLAGS_EN
  logic carry, zero, ovf, sel_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .select (select),
    .res    (res)
`ifdef ALU_FLAGS_EN
    ,
    .carry  (carry),
    .zero   (zero),
    .ovf    (ovf),
    .sel_err(sel_err)
`endif
  );

  function automatic int sel_index(input logic [7:0] s);
    int idx = -1;
    if ($countones(s) != 1) return -1;
    for (int i = 0; i < 8; i++) if (s[i]) idx = i;
    return idx;
  endfunction

  function automatic int to_signed(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference: plain integer arithmetic on 0..255 values.
  function automatic logic [7:0] model_res(input int a, input int b, input logic [7:0] s);
    int sh = b % 8;
    int r;
    case (sel_index(s))
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - (a | b);
      6: r = (a * (1 << sh)) % 256;
      7: r = a / (1 << sh);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic logic model_carry(input int a, input int b, input logic [7:0] s);
    int k = sel_index(s);
    if (k == 0) return (a + b) > 255;
    if (k == 1) return a < b;
    return 1'b0;
  endfunction

  function automatic logic model_ovf(input int a, input int b, input logic [7:0] s);
    int k = sel_index(s);
    int v;
    if (k == 0) v = to_signed(a) + to_signed(b);
    else if (k == 1) v = to_signed(a) - to_signed(b);
    else return 1'b0;
    return (v > 127) || (v < -128);
  endfunction

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one op on the falling edge, check outputs 1 ns after the next rising edge.
  task automatic step(input string tag, input logic r, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] s);
    logic [7:0] exp_res;
    @(negedge clk);
    rst = r; op1 = a; op2 = b; select = s;
    exp_res = r ? 8'h00 : model_res(int'(a), int'(b), s);
    @(posedge clk);
    #1;
    check8(tag, res, exp_res);
`ifdef ALU_FLAGS_EN
    check1({tag, ".carry"}, carry, r ? 1'b0 : model_carry(int'(a), int'(b), s));
    check1({tag, ".ovf"}, ovf, r ? 1'b0 : model_ovf(int'(a), int'(b), s));
    check1({tag, ".zero"}, zero, r ? 1'b0 : (exp_res == 8'h00));
    check1({tag, ".sel_err"}, sel_err, r ? 1'b0 : ($countones(s) != 1));
`endif
  endtask

  initial begin
    logic [7:0] seq [8];
    logic [7:0] a, b, s;
    rst = 1'b1; op1 = 8'h00; op2 = 8'h00; select = 8'h00;

    // Reset holds res at zero even with a valid SUB on the inputs.
    step("reset0", 1'b1, 8'hAB, 8'hCC, 8'h02);
    step("reset1", 1'b1, 8'hAB, 8'hCC, 8'h02);
    step("first_after_reset", 1'b0, 8'hAB, 8'hCC, 8'h02);
    check8("first_after_reset_const", res, 8'hDF);

    step("and", 1'b0, 8'hAB, 8'hCC, 8'h04);
    check8("and_const", res, 8'h88);
    step("or", 1'b0, 8'hAB, 8'hCC, 8'h08);
    check8("or_const", res, 8'hEF);
    step("xor", 1'b0, 8'hAB, 8'hCC, 8'h10);
    check8("xor_const", res, 8'h67);
    step("nor", 1'b0, 8'hAB, 8'hCC, 8'h20);
    check8("nor_const", res, 8'h10);
    step("shl4", 1'b0, 8'hAB, 8'hCC, 8'h40);
    check8("shl4_const", res, 8'hB0);
    step("shr4", 1'b0, 8'hAB, 8'hCC, 8'h80);
    check8("shr4_const", res, 8'h0A);
    step("shl0", 1'b0, 8'hAB, 8'h00, 8'h40);
    check8("shl0_const", res, 8'hAB);
    step("shr0", 1'b0, 8'hAB, 8'h00, 8'h80);
    check8("shr0_const", res, 8'hAB);
    step("shl_upper_ignored", 1'b0, 8'hAB, 8'hF9, 8'h40);
    check8("shl_upper_const", res, 8'h56);
    step("add_carry", 1'b0, 8'hAB, 8'hCC, SEL_ADD);
    check8("add_carry_const", res, 8'h77);
    step("sub_borrow", 1'b0, 8'hAB, 8'hCC, SEL_SUB);
    step("add_ovf", 1'b0, 8'h7F, 8'h01, SEL_ADD);
    check8("add_ovf_const", res, 8'h80);
    step("sub_zero", 1'b0, 8'h05, 8'h05, SEL_SUB);
    check8("sub_zero_const", res, 8'h00);
    step("sel_none", 1'b0, 8'hAB, 8'hCC, 8'h00);
    check8("sel_none_const", res, 8'h00);
    step("sel_multi", 1'b0, 8'hAB, 8'hCC, 8'h06);
    check8("sel_multi_const", res, 8'h00);

    // Back-to-back: a different op every cycle, each checked exactly one edge later.
    seq = '{SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_XOR, SEL_NOR, SEL_SHL, SEL_SHR};
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      step("b2b", 1'b0, a, b, seq[i]);
    end

    // Mid-stream reset overrides a valid op, then results resume.
    step("mid_reset", 1'b1, 8'h12, 8'h34, SEL_ADD);
    step("post_mid_reset", 1'b0, 8'h12, 8'h34, SEL_ADD);
    check8("post_mid_reset_const", res, 8'h46);

    // Randomized ops, mostly valid one-hot selects with some arbitrary bytes.
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) s = 8'($urandom_range(0, 255));
      else s = 8'(1 << $urandom_range(0, 7));
      step("rand", ($urandom_range(0, 49) == 0), a, b, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit registered arithmetic/logic unit with a one-hot operation select.
- Combinational datapath computes the selected function of op1/op2; the result is captured into an output register on each clock.
- Used as a leaf datapath block; no handshake, it accepts a new operation every cycle.

Parameters:
- WIDTH, 8, operand/result width in bits; select stays 8 bits one-hot regardless.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- op1  input  WIDTH  operand A
- op2  input  WIDTH  operand B (shift amount source for shift ops)
- select  input  8  one-hot operation select
- res  output  WIDTH  registered result

Behaviour:
- Single clock domain; all state updates on rising clk. Reset is synchronous, active-high. While rst=1 at a clock edge, res <= 0 (and all flags <= 0 when the feature is enabled).
- Latency: res reflects the op1/op2/select values sampled at the previous rising edge, so latency is 1 cycle with throughput of 1 op/cycle.
- Operation per select (exactly one bit set):
  - bit0: ADD, op1+op2 mod 2^WIDTH
  - bit1: SUB, op1-op2 mod 2^WIDTH (two's complement)
  - bit2: AND
  - bit3: OR
  - bit4: XOR
  - bit5: NOR
  - bit6: SHL, op1 logical shift left by op2[2:0], zero fill
  - bit7: SHR, op1 logical shift right by op2[2:0], zero fill
- Shift amount uses only op2[2:0]; upper op2 bits are ignored. A shift amount of 0 passes op1 unchanged.
- Invalid select (all zero, or more than one bit set): res <= 0 at the next edge. This is never a priority decode.
- Reset asserted mid-stream overrides any operation in that cycle. The first valid result after reset deassertion appears one edge after the first non-reset edge.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- With the macro defined, four extra 1-bit registered outputs are added, all updated on the same edge and with the same latency as res:
  - carry: ADD carry-out, or SUB borrow (op1<op2 unsigned); 0 for all other ops
  - zero: 1 when the registered res==0
  - ovf: signed overflow for ADD/SUB; 0 for all other ops
  - sel_err: 1 when select is invalid
- Without the macro, these ports and their logic are absent and res behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - one-hot select constants SEL_ADD..SEL_SHR (8'b0000_0001 .. 8'b1000_0000)
  - localparam for the shift-amount width (3)
- One natural sub-module, alu_core: a purely combinational op1/op2/select -> result (+flags) function. The top level adds only the reset/output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with op1=0xAB, op2=0xCC, select=8'h02 -> res=0x00. After deassertion, res=0xDF one cycle later.
- Logic ops, op1=0xAB, op2=0xCC:
  - select=0x04 -> 0x88
  - select=0x08 -> 0xEF
  - select=0x10 -> 0x67
  - select=0x20 -> 0x10
- Shifts, op1=0xAB, op2=0xCC (amount 4):
  - select=0x40 -> 0xB0
  - select=0x80 -> 0x0A
  - op2=0x00 with either shift -> 0xAB
- Arithmetic:
  - ADD 0xAB+0xCC -> 0x77, carry=1 (flags build)
  - SUB 0xAB-0xCC -> 0xDF, carry=1
  - ADD 0x7F+0x01 -> 0x80, ovf=1
  - SUB 0x05-0x05 -> 0x00, zero=1
- Invalid select: select=0x00 and select=0x06 -> res=0x00, sel_err=1 (flags build).
- Back-to-back: change select every cycle across all 8 ops -> each result appears exactly 1 cycle after its inputs, with no bubbles.
